// File: rtl/dbg_cmd_pkg.sv
// Shared definitions for the debug command sequencer: drop counter width
// and the well-known debug channel indices carried in the IR.
package dbg_cmd_pkg;

   // Width of the saturating dropped-command counter
   localparam int DROP_CNT_W = 8;

   // Debug channel indices selected by the JTAG IR
   localparam int CH_OCIMEM    = 0;
   localparam int CH_TRACEMEM  = 1;
   localparam int CH_BREAK     = 2;
   localparam int CH_TRACECTRL = 3;

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Generic command queue: DEPTH x WIDTH register file with first-word-fall-
// through read. A push while full is ignored unless a pop happens in the
// same cycle, in which case the freed slot is reused.
module dbg_cmd_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem[rd_ptr];

   // Storage write; payload needs no reset since empty masks it downstream
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dbg_cmd_sequencer.sv
// JTAG debug command sequencer: brings the TCK-domain update strobes into
// clk, latches IR, captures IR/DR pairs into a queue and hands them out on
// a valid/ready stream with per-channel action / no-action pulses.
module dbg_cmd_sequencer
   import dbg_cmd_pkg::*;
#(
   parameter int IR_WIDTH    = 2,
   parameter int DR_WIDTH    = 38,
   parameter int ACT_BIT     = 35,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2,
   localparam int NUM_CH     = 2 ** IR_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [IR_WIDTH-1:0]           ir_in,
   input  logic [DR_WIDTH-1:0]           sr,
   input  logic                          vs_uir,
   input  logic                          vs_udr,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [IR_WIDTH-1:0]           cmd_ch,
   output logic [DR_WIDTH-1:0]           cmd_data,
   output logic [NUM_CH-1:0]             take_action,
   output logic [NUM_CH-1:0]             take_no_action,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic [DROP_CNT_W-1:0]         drop_cnt
);

   typedef struct packed {
      logic [IR_WIDTH-1:0] ch;
      logic [DR_WIDTH-1:0] data;
   } entry_t;

   localparam int ENTRY_W = IR_WIDTH + DR_WIDTH;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic [SYNC_STAGES-1:0] uir_sync;
   logic [SYNC_STAGES-1:0] udr_sync;
   logic [SYNC_STAGES-1:0] sync_primed;
   logic                   uir_prev;
   logic                   udr_prev;
   logic                   uir_armed;
   logic                   udr_armed;
   logic                   uir_rise;
   logic                   udr_rise;
   logic                   uir_synced;
   logic                   udr_synced;
   logic                   sample_real;
   logic [IR_WIDTH-1:0]    ir_lat;
   entry_t                 push_entry;
   entry_t                 head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;
   logic                   drop;
   logic [NUM_CH-1:0]      ch_onehot;

   assign uir_synced  = uir_sync[SYNC_STAGES-1];
   assign udr_synced  = udr_sync[SYNC_STAGES-1];
   assign sample_real = sync_primed[SYNC_STAGES-1];
   // An edge only counts once a genuine low has been seen after reset
   assign uir_rise    = uir_synced & ~uir_prev & uir_armed;
   assign udr_rise    = udr_synced & ~udr_prev & udr_armed;

   // Strobe synchronisers, edge registers and post-reset arming
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uir_sync    <= '0;
         udr_sync    <= '0;
         sync_primed <= '0;
         uir_prev    <= 1'b0;
         udr_prev    <= 1'b0;
         uir_armed   <= 1'b0;
         udr_armed   <= 1'b0;
      end else begin
         uir_sync    <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
         udr_sync    <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
         sync_primed <= {sync_primed[SYNC_STAGES-2:0], 1'b1};
         uir_prev    <= uir_synced;
         udr_prev    <= udr_synced;
         uir_armed   <= uir_armed | (sample_real & ~uir_synced);
         udr_armed   <= udr_armed | (sample_real & ~udr_synced);
      end
   end

   // IR latch on each update-IR edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ir_lat <= '0;
      else if (uir_rise) ir_lat <= ir_in;
   end

   // A coincident update-IR takes effect for the capture in the same cycle
   assign push_entry.ch   = uir_rise ? ir_in : ir_lat;
   assign push_entry.data = sr;

   dbg_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (udr_rise),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign cmd_valid = ~fifo_empty;
   assign cmd_ch    = fifo_empty ? '0 : head.ch;
   assign cmd_data  = fifo_empty ? '0 : head.data;
   assign pop       = cmd_valid & cmd_ready;
   assign drop      = udr_rise & fifo_full & ~pop;
   assign ch_onehot = NUM_CH'(1) << cmd_ch;

   // One-cycle action / no-action pulse for each accepted command
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         take_action    <= '0;
         take_no_action <= '0;
      end else begin
         take_action    <= (pop &  cmd_data[ACT_BIT]) ? ch_onehot : '0;
         take_no_action <= (pop & ~cmd_data[ACT_BIT]) ? ch_onehot : '0;
      end
   end

   // Sticky overflow and saturating drop count; a new drop beats a clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         drop_cnt <= clr_overflow ? DROP_CNT_W'(1) : sat_inc(drop_cnt);
      end else if (clr_overflow) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_dbg_cmd_sequencer.sv
// Directed bench for dbg_cmd_sequencer with default parameters.
module tb_dbg_cmd_sequencer;
   import dbg_cmd_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        vs_uir;
   logic        vs_udr;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_ch;
   logic [37:0] cmd_data;
   logic [3:0]  take_action;
   logic [3:0]  take_no_action;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        clr_overflow;
   logic [7:0]  drop_cnt;

   int errors = 0;
   int checks = 0;

   dbg_cmd_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .ir_in          (ir_in),
      .sr             (sr),
      .vs_uir         (vs_uir),
      .vs_udr         (vs_udr),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_ch         (cmd_ch),
      .cmd_data       (cmd_data),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .fifo_level     (fifo_level),
      .overflow       (overflow),
      .clr_overflow   (clr_overflow),
      .drop_cnt       (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic uir_pulse(input logic [1:0] v);
      ir_in  = v;
      vs_uir = 1'b1;
      tick(2);
      vs_uir = 1'b0;
      tick(2);
   endtask

   task automatic udr_pulse(input logic [37:0] d);
      sr     = d;
      vs_udr = 1'b1;
      tick(2);
      vs_udr = 1'b0;
      tick(2);
   endtask

   initial begin
      reset        = 1'b1;
      ir_in        = '0;
      sr           = '0;
      vs_uir       = 1'b0;
      vs_udr       = 1'b0;
      cmd_ready    = 1'b0;
      clr_overflow = 1'b0;
      tick(2);
      chk("rst_valid", 64'(cmd_valid), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_data", 64'(cmd_data), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_act", 64'({take_action, take_no_action}), 64'd0);
      reset = 1'b0;
      tick(5);

      // Single action command on the break channel
      uir_pulse(2'(CH_BREAK));
      ir_in  = 2'd3;
      sr     = 38'h2A_DEADBEEF;
      vs_udr = 1'b1;
      tick(2);
      chk("lat_edge2", 64'(cmd_valid), 64'd0);
      tick(1);
      chk("lat_edge3", 64'(cmd_valid), 64'd1);
      chk("t1_ch", 64'(cmd_ch), 64'd2);
      chk("t1_data", 64'(cmd_data), 64'h2A_DEADBEEF);
      chk("t1_level", 64'(fifo_level), 64'd1);
      vs_udr    = 1'b0;
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      chk("t1_act", 64'(take_action), 64'b0100);
      chk("t1_noact", 64'(take_no_action), 64'd0);
      chk("t1_empty", 64'(cmd_valid), 64'd0);
      tick(1);
      chk("t1_act_end", 64'(take_action), 64'd0);
      tick(2);

      // No-action command on channel 0
      uir_pulse(2'(CH_OCIMEM));
      udr_pulse(38'h01_12345678);
      chk("t2_valid", 64'(cmd_valid), 64'd1);
      chk("t2_ch", 64'(cmd_ch), 64'd0);
      chk("t2_data", 64'(cmd_data), 64'h01_12345678);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      chk("t2_noact", 64'(take_no_action), 64'b0001);
      chk("t2_act", 64'(take_action), 64'd0);
      chk("t2_level", 64'(fifo_level), 64'd0);

      // Fill past capacity, then drain in push order
      uir_pulse(2'(CH_TRACEMEM));
      for (int i = 0; i < 6; i++) udr_pulse(38'(i + 1));
      chk("t3_level", 64'(fifo_level), 64'd4);
      chk("t3_ovf", 64'(overflow), 64'd1);
      chk("t3_drop", 64'(drop_cnt), 64'd2);
      for (int i = 0; i < 4; i++) begin
         chk("t3_head", 64'(cmd_data), 64'(i + 1));
         chk("t3_ch", 64'(cmd_ch), 64'd1);
         cmd_ready = 1'b1;
         tick(1);
         cmd_ready = 1'b0;
         chk("t3_noact", 64'(take_no_action), 64'b0010);
      end
      chk("t3_drained", 64'(fifo_level), 64'd0);
      chk("t3_ovf_kept", 64'(overflow), 64'd1);

      // Clear alone
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;
      chk("clr_ovf", 64'(overflow), 64'd0);
      chk("clr_drop", 64'(drop_cnt), 64'd0);

      // Full with push and pop in the same cycle
      uir_pulse(2'(CH_TRACECTRL));
      for (int i = 0; i < 4; i++) udr_pulse(38'(16 + i));
      chk("t4_full", 64'(fifo_level), 64'd4);
      sr     = 38'h14;
      vs_udr = 1'b1;
      tick(2);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      vs_udr    = 1'b0;
      chk("t4_level", 64'(fifo_level), 64'd4);
      chk("t4_drop", 64'(drop_cnt), 64'd0);
      chk("t4_ovf", 64'(overflow), 64'd0);
      chk("t4_noact", 64'(take_no_action), 64'b1000);
      chk("t4_head", 64'(cmd_data), 64'h11);
      tick(2);
      for (int i = 0; i < 4; i++) begin
         chk("t4_order", 64'(cmd_data), 64'(17 + i));
         cmd_ready = 1'b1;
         tick(1);
         cmd_ready = 1'b0;
      end
      chk("t4_drained", 64'(fifo_level), 64'd0);

      // Saturating drop counter: 4 pushes fill, 300 more are dropped
      for (int i = 0; i < 304; i++) udr_pulse(38'(i));
      chk("t5_sat", 64'(drop_cnt), 64'd255);
      chk("t5_ovf", 64'(overflow), 64'd1);
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;
      chk("t5_clr_drop", 64'(drop_cnt), 64'd0);
      chk("t5_clr_ovf", 64'(overflow), 64'd0);
      vs_udr = 1'b1;
      tick(2);
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;
      vs_udr = 1'b0;
      chk("t5_race_drop", 64'(drop_cnt), 64'd1);
      chk("t5_race_ovf", 64'(overflow), 64'd1);
      tick(2);

      // Reset with 3 entries queued
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      chk("t6_level3", 64'(fifo_level), 64'd3);
      reset = 1'b1;
      #1;
      chk("t6_async_valid", 64'(cmd_valid), 64'd0);
      chk("t6_async_level", 64'(fifo_level), 64'd0);
      chk("t6_async_data", 64'(cmd_data), 64'd0);
      chk("t6_async_act", 64'({take_action, take_no_action}), 64'd0);
      chk("t6_async_ovf", 64'({overflow, drop_cnt}), 64'd0);
      sr     = 38'h3_00000055;
      vs_udr = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(8);
      chk("t6_held_high", 64'(cmd_valid), 64'd0);
      vs_udr = 1'b0;
      tick(3);
      vs_udr = 1'b1;
      tick(3);
      chk("t6_new_valid", 64'(cmd_valid), 64'd1);
      chk("t6_new_ch", 64'(cmd_ch), 64'd0);
      chk("t6_new_data", 64'(cmd_data), 64'h3_00000055);
      vs_udr = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
